// File: rtl/alu_address_sequencer_if.sv
// Decoder/dataflow-facing signal bundle of the ALU address sequencer.
// The slave side is the sequencer; the master side is the decoder/memory/dataflow.
interface alu_address_sequencer_if;
  logic       start;
  logic [1:0] mode;
  logic       ready;
  logic       alu_carry;
  logic       abort;
  logic       alu_read_enable;
  logic       alu_abl_write_enable;
  logic       alu_sb_write_enable;
  logic       alu_op_add_low;
  logic       alu_op_add_high;
  logic       alu_carry_inject;
  logic       abh_force_zero;
  logic       busy;
  logic       done;
  logic       page_cross;
  logic       timeout;

  modport slave (
    input  start, mode, ready, alu_carry, abort,
    output alu_read_enable, alu_abl_write_enable, alu_sb_write_enable,
           alu_op_add_low, alu_op_add_high, alu_carry_inject, abh_force_zero,
           busy, done, page_cross, timeout
  );

  modport master (
    output start, mode, ready, alu_carry, abort,
    input  alu_read_enable, alu_abl_write_enable, alu_sb_write_enable,
           alu_op_add_low, alu_op_add_high, alu_carry_inject, abh_force_zero,
           busy, done, page_cross, timeout
  );
endinterface

// File: rtl/alu_address_sequencer.sv
// 6502-style indexed effective-address sequencer: low-byte add, ABL drive,
// optional high-byte fix-up and SB drive, with a memory-ready stall watchdog.
module alu_address_sequencer #(
  parameter int STALL_CNT_W = 4,
  parameter int MAX_STALL   = 15
) (
  input logic                   clk,
  input logic                   nrst,
  alu_address_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADD_LOW    = 3'd1,
    S_DRIVE_LOW  = 3'd2,
    S_FIX_HIGH   = 3'd3,
    S_DRIVE_HIGH = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(MAX_STALL - 1);

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic                   carry_q, carry_d;
  logic                   pc_q, pc_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   stalling;

  // State and datapath-control registers; async active-low reset to IDLE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      carry_q <= 1'b0;
      pc_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      pc_q    <= pc_d;
      stall_q <= stall_d;
    end
  end

  // Next-state and output decode; abort and watchdog override the normal flow.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    pc_d     = pc_q;
    stall_d  = '0;
    stalling = 1'b0;

    bus.alu_read_enable      = 1'b0;
    bus.alu_abl_write_enable = 1'b0;
    bus.alu_sb_write_enable  = 1'b0;
    bus.alu_op_add_low       = 1'b0;
    bus.alu_op_add_high      = 1'b0;
    bus.alu_carry_inject     = 1'b0;
    bus.abh_force_zero       = 1'b0;
    bus.busy                 = (state_q != S_IDLE);
    bus.done                 = 1'b0;
    bus.page_cross           = pc_q;
    bus.timeout              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort && (bus.mode != 2'b11)) begin
          state_d = S_ADD_LOW;
          mode_d  = bus.mode;
          pc_d    = 1'b0;
        end
      end
      S_ADD_LOW: begin
        bus.alu_op_add_low  = 1'b1;
        bus.alu_read_enable = bus.ready;
        stalling            = !bus.ready;
        if (bus.ready) begin
          carry_d = bus.alu_carry;
          state_d = S_DRIVE_LOW;
        end
      end
      S_DRIVE_LOW: begin
        bus.alu_abl_write_enable = 1'b1;
        bus.abh_force_zero       = (mode_q == 2'b00);
        stalling                 = !bus.ready;
        if (bus.ready) begin
          // Zero-page and non-crossing absolute reads finish here; writes
          // always take the fix-up slot as a dummy cycle.
          if ((mode_q == 2'b00) || ((mode_q == 2'b01) && !carry_q))
            state_d = S_DONE;
          else
            state_d = S_FIX_HIGH;
        end
      end
      S_FIX_HIGH: begin
        bus.alu_op_add_high  = 1'b1;
        bus.alu_carry_inject = carry_q;
        bus.alu_read_enable  = bus.ready;
        stalling             = !bus.ready;
        if (bus.ready) state_d = S_DRIVE_HIGH;
      end
      S_DRIVE_HIGH: begin
        bus.alu_sb_write_enable = 1'b1;
        stalling                = !bus.ready;
        if (bus.ready) state_d = S_DONE;
      end
      S_DONE: begin
        bus.done       = 1'b1;
        bus.page_cross = carry_q;
        pc_d           = carry_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (stalling) begin
      if (stall_q == STALL_LAST) begin
        state_d     = S_IDLE;
        bus.timeout = 1'b1;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      stall_d        = '0;
      pc_d           = pc_q;
      bus.timeout    = 1'b0;
      bus.done       = 1'b0;
      bus.page_cross = pc_q;
    end
  end

endmodule

// File: tb/tb_alu_address_sequencer.sv
// Directed bench for alu_address_sequencer: table of address-calculation
// transactions plus hand-written reset, stall, timeout and abort sequences.
module tb_alu_address_sequencer;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_fail;

  alu_address_sequencer_if bus ();

  alu_address_sequencer #(.STALL_CNT_W(4), .MAX_STALL(15)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       carry;
    int         fix_stall;
    int         exp_lat;
    bit         exp_fix;
    bit         exp_fz;
    bit         exp_inj;
    bit         exp_pc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus.alu_read_enable, bus.alu_abl_write_enable, bus.alu_sb_write_enable,
            bus.alu_op_add_low, bus.alu_op_add_high, bus.alu_carry_inject,
            bus.abh_force_zero, bus.busy, bus.done, bus.page_cross, bus.timeout};
  endfunction

  // One transaction: start presented before an edge, then per-cycle observation
  // at the falling edge; ready is pulled low for fix_stall cycles in FIX_HIGH.
  task automatic run_txn(input logic [1:0] m, input logic c, input int fix_stall,
                         output int lat, output bit saw_fix, output bit saw_fz,
                         output bit inj, output bit pc, output bit got_done,
                         output bit re_bad, output bit overlap);
    int stalls;
    lat = 0; saw_fix = 0; saw_fz = 0; inj = 0; pc = 0;
    got_done = 0; re_bad = 0; overlap = 0;
    stalls = fix_stall;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.alu_carry = c; bus.ready = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 40 && !got_done; n++) begin
      @(negedge clk);
      bus.ready = 1'b1;
      if (bus.alu_op_add_high && stalls > 0) begin
        bus.ready = 1'b0;
        stalls--;
      end
      #1;
      if (bus.alu_abl_write_enable && bus.alu_sb_write_enable) overlap = 1;
      if ((bus.alu_abl_write_enable || bus.alu_sb_write_enable) && bus.alu_read_enable) re_bad = 1;
      if (bus.alu_op_add_high) begin
        saw_fix = 1;
        inj = bus.alu_carry_inject;
        if (!bus.ready && bus.alu_read_enable) re_bad = 1;
      end
      if (bus.alu_abl_write_enable) saw_fz = bus.abh_force_zero;
      if (bus.done) begin
        got_done = 1;
        lat = n;
        pc = bus.page_cross;
      end
    end
    bus.ready = 1'b1;
  endtask

  initial begin
    int lat;
    bit saw_fix, saw_fz, inj, pc, got_done, re_bad, overlap;
    bit seen;
    int when;

    n_cmp = 0;
    n_fail = 0;
    vecs[0] = '{2'b00, 1'b1, 0, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{2'b01, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 1'b1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{2'b10, 1'b0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 1'b1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{2'b01, 1'b1, 3, 8, 1'b1, 1'b0, 1'b1, 1'b1};

    bus.start = 1'b0; bus.mode = 2'b00; bus.ready = 1'b1;
    bus.alu_carry = 1'b0; bus.abort = 1'b0;
    nrst = 1'b0;
    #12;
    chk("reset_outputs", int'(outs()), 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", int'(outs()), 0);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].mode, vecs[i].carry, vecs[i].fix_stall,
              lat, saw_fix, saw_fz, inj, pc, got_done, re_bad, overlap);
      chk($sformatf("v%0d_done", i), int'(got_done), 1);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_fix_high", i), int'(saw_fix), int'(vecs[i].exp_fix));
      chk($sformatf("v%0d_force_zero", i), int'(saw_fz), int'(vecs[i].exp_fz));
      chk($sformatf("v%0d_carry_inject", i), int'(inj), int'(vecs[i].exp_inj));
      chk($sformatf("v%0d_page_cross", i), int'(pc), int'(vecs[i].exp_pc));
      chk($sformatf("v%0d_abl_sb_overlap", i), int'(overlap), 0);
      chk($sformatf("v%0d_read_in_drive", i), int'(re_bad), 0);
    end

    // page_cross from the last transaction (1) holds in IDLE
    @(negedge clk);
    @(negedge clk);
    chk("page_cross_hold", int'(bus.page_cross), 1);
    chk("idle_busy", int'(bus.busy), 0);

    // next accepted start clears page_cross
    bus.start = 1'b1; bus.mode = 2'b01; bus.alu_carry = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("page_cross_cleared", int'(bus.page_cross), 0);
    chk("busy_after_start", int'(bus.busy), 1);
    repeat (4) @(negedge clk);

    // reserved mode is ignored
    bus.start = 1'b1; bus.mode = 2'b11;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.done) seen = 1;
    end
    bus.start = 1'b0;
    chk("mode11_ignored", int'(seen), 0);

    // start together with abort in IDLE is ignored
    bus.start = 1'b1; bus.mode = 2'b00; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_blocks_start", int'(bus.busy), 0);

    // watchdog: ready low from acceptance, timeout on the 15th stalled cycle
    bus.start = 1'b1; bus.mode = 2'b01; bus.ready = 1'b0; bus.alu_carry = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    seen = 0; when = 0;
    for (int n = 1; n <= 30 && when == 0; n++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      if (bus.timeout) when = n;
      if (n < 15 && bus.alu_read_enable) seen = 1;
    end
    chk("timeout_cycle", when, 15);
    @(negedge clk);
    chk("timeout_busy_drop", int'(bus.busy), 0);
    chk("timeout_timeout_pulse", int'(bus.timeout), 0);
    chk("timeout_no_done", int'(seen), 0);
    chk("timeout_page_cross", int'(bus.page_cross), 0);
    bus.ready = 1'b1;

    // abort in DRIVE_HIGH
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b01; bus.alu_carry = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    when = 0;
    for (int n = 1; n <= 10 && when == 0; n++) begin
      @(negedge clk);
      if (bus.alu_sb_write_enable) when = n;
    end
    chk("abort_reach_drive_high", when, 4);
    bus.abort = 1'b1;
    #1 chk("abort_no_timeout", int'(bus.timeout), 0);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    seen = bus.done;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("abort_no_done", int'(seen), 0);

    // reset in FIX_HIGH, then a normal transaction
    bus.start = 1'b1; bus.mode = 2'b10; bus.alu_carry = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    when = 0;
    for (int n = 1; n <= 10 && when == 0; n++) begin
      @(negedge clk);
      if (bus.alu_op_add_high) when = n;
    end
    chk("reach_fix_high", when, 3);
    #1 nrst = 1'b0;
    #1 chk("reset_mid_outputs", int'(outs()), 0);
    @(negedge clk);
    nrst = 1'b1;
    chk("reset_mid_no_done", int'(bus.done), 0);
    run_txn(2'b00, 1'b0, 0, lat, saw_fix, saw_fz, inj, pc, got_done, re_bad, overlap);
    chk("after_reset_done", int'(got_done), 1);
    chk("after_reset_latency", lat, 3);
    chk("after_reset_page_cross", int'(pc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/alu_address_sequencer.md
Name: alu_address_sequencer

Overview:
Sequences the ALU output register through 6502-style indexed effective-address calculation: base_low + index, with an optional high-byte fix-up cycle on page crossing.
- Drives the register's load strobe, ALU-to-address-bus-low (ABL) drive and ALU-to-stack-bus (SB) drive, plus ALU op selects.
- Sits between the instruction decoder (start/mode) and the dataflow registers.
- Includes a stall watchdog on the memory-ready line.

Parameters:
STALL_CNT_W, 4, width of stall counter
MAX_STALL, 15, consecutive ready-low cycles in a non-idle state before abort (must fit in STALL_CNT_W bits, nonzero)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
start  in  1  request new address calculation; sampled only in IDLE
mode  in  2  00 zero-page indexed, 01 absolute indexed read, 10 absolute indexed write, 11 reserved
ready  in  1  memory ready; low stalls sequencer
alu_carry  in  1  carry-out of combinational ALU, valid during ADD_LOW
abort  in  1  synchronous cancel from decoder (interrupt/reset sequencing)
alu_read_enable  out  1  load strobe to ALU output register
alu_abl_write_enable  out  1  ALU register drives ABL
alu_sb_write_enable  out  1  ALU register drives SB (to ABH path)
alu_op_add_low  out  1  ALU computes base_low + index
alu_op_add_high  out  1  ALU computes base_high + alu_carry_inject
alu_carry_inject  out  1  carry-in for high-byte add
abh_force_zero  out  1  ABH forced to 0x00 (zero-page modes)
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
page_cross  out  1  registered carry from low add; held until next accepted start
timeout  out  1  one-cycle pulse on stall abort

Behaviour:
- Asynchronous reset state: IDLE, mode_q=00, carry_q=0, stall_cnt=0. All outputs 0 during and after reset until a start is accepted.
- States: IDLE, ADD_LOW, DRIVE_LOW, FIX_HIGH, DRIVE_HIGH, DONE. All outputs are decoded from state and registers; there are no combinational paths from start/mode.
- IDLE: start=1 and mode!=11 -> ADD_LOW; mode latched into mode_q, page_cross cleared. start with mode=11 is ignored and the block stays IDLE. The ready level is irrelevant in IDLE.
- ADD_LOW: alu_op_add_low=1; alu_read_enable=ready.
  - If ready: carry_q<=alu_carry, -> DRIVE_LOW.
  - If !ready: hold state.
- DRIVE_LOW: alu_abl_write_enable=1; abh_force_zero=(mode_q==00). If ready:
  - mode_q=00 -> DONE.
  - mode_q=01 and carry_q=0 -> DONE.
  - Otherwise -> FIX_HIGH. Mode 10 always takes FIX_HIGH (dummy cycle).
- FIX_HIGH: alu_op_add_high=1; alu_carry_inject=carry_q; alu_read_enable=ready. If ready -> DRIVE_HIGH.
- DRIVE_HIGH: alu_sb_write_enable=1. If ready -> DONE.
- DONE: done=1, page_cross=carry_q, -> IDLE unconditionally (ready ignored). A start in DONE is ignored; it must be presented in IDLE.
- alu_abl_write_enable and alu_sb_write_enable are never asserted together. alu_read_enable is never asserted in a drive state.
- Latency from accepted start edge to done:
  - 3 cycles with no stall (zero-page, or absolute with no page cross).
  - 5 cycles with fix-up.
  - Each ready-low cycle adds 1.
- Stall watchdog:
  - stall_cnt increments each cycle in ADD_LOW..DRIVE_HIGH with ready=0, and clears on ready=1 or in IDLE/DONE.
  - When stall_cnt==MAX_STALL-1 and ready=0: next state IDLE, timeout=1 for that cycle, no done, page_cross unchanged.
- abort=1 in any non-IDLE state: next state IDLE, no done, no timeout, stall_cnt cleared. abort overrides ready, timeout and normal transitions. abort in IDLE together with start: start is ignored.
- Reset mid-operation: immediate return to IDLE and all outputs 0. No done is generated.

Test Plan:
- Reset, then start, mode=00, alu_carry=1, ready=1 -> DRIVE_LOW with abh_force_zero=1; done on cycle 3; page_cross=1; no FIX_HIGH visited.
- start, mode=01, alu_carry=0 -> done cycle 3, page_cross=0; start, mode=01, alu_carry=1 -> FIX_HIGH with alu_carry_inject=1, DRIVE_HIGH with alu_sb_write_enable=1, done cycle 5.
- start, mode=10, alu_carry=0 -> FIX_HIGH with alu_carry_inject=0, done cycle 5; mode=11 start -> busy stays 0, no done.
- mode=01 with carry; ready low 3 cycles in FIX_HIGH -> alu_read_enable=0 during stall, done cycle 8; checker confirms ABL/SB enables never both high.
- ready held low in ADD_LOW with MAX_STALL=15 -> timeout pulse after 15 stalled cycles, busy drops, no done; abort asserted in DRIVE_HIGH -> IDLE next cycle, no done.
- nrst asserted in FIX_HIGH -> all outputs 0 immediately; new start after release completes normally.
